// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared FSM encoding and requester count for rr_arbiter8
package rr_arbiter8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between requesters and rr_arbiter8
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_arbiter8_dec3to8.sv
// rtl/rr_arbiter8_dec3to8.sv - 3-to-8 one-hot decoder
module dec3to8 (
  input  logic [2:0] idx,
  output logic [7:0] onehot
);

  assign onehot = 8'b0000_0001 << idx;

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold-time limit and one-cycle gap
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave bus
);

  arb_state_t         state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]   hold_cnt, hold_n;
  logic [IDX_W-1:0]   gnt_idx_q, idx_n;
  logic               gnt_valid_q, valid_n;
  logic               timeout_q, timeout_n;
  logic               rel_hit, exp_hit;
  logic [NUM_REQ-1:0] dec_out;

  // First set request bit at or above p, wrapping 7 -> 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic             found;
    logic [IDX_W-1:0] c;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = p + IDX_W'(i);
      if (!found && r[c]) begin
        rr_pick = c;
        found   = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      hold_cnt    <= hold_n;
      gnt_idx_q   <= idx_n;
      gnt_valid_q <= valid_n;
      timeout_q   <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    idx_n     = gnt_idx_q;
    valid_n   = gnt_valid_q;
    timeout_n = 1'b0;
    rel_hit   = 1'b0;
    exp_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en && (|bus.req)) begin
          state_n = GRANT;
          idx_n   = rr_pick(bus.req, ptr);
          valid_n = 1'b1;
          hold_n  = '0;
        end
      end
      GRANT: begin
        // en and other requesters are deliberately ignored while a grant is held
        rel_hit = !bus.req[gnt_idx_q];
        exp_hit = (hold_cnt == CNT_W'(MAX_HOLD - 1));
        hold_n  = hold_cnt + CNT_W'(1);
        if (rel_hit || exp_hit) begin
          state_n   = GAP;
          valid_n   = 1'b0;
          ptr_n     = gnt_idx_q + IDX_W'(1);
          timeout_n = !rel_hit;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  dec3to8 u_dec (
    .idx    (gnt_idx_q),
    .onehot (dec_out)
  );

  assign bus.gnt       = dec_out & {NUM_REQ{gnt_valid_q}};
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed self-checking bench for rr_arbiter8
module tb_rr_arbiter8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   k;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                         input logic v, input logic t);
    chk({tag, "_gnt"}, bus.gnt, g);
    chk({tag, "_idx"}, {5'd0, bus.gnt_idx}, {5'd0, idx});
    chk({tag, "_valid"}, {7'd0, bus.gnt_valid}, {7'd0, v});
    chk({tag, "_timeout"}, {7'd0, bus.timeout}, {7'd0, t});
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    #3;
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single requester: grant, release, GAP, IDLE
    bus.en  = 1'b1;
    bus.req = 8'h01;
    tick();
    chk_out("single_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    chk_out("single_gap", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_out("single_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // Full rotation from ptr=0, each holder releasing after 3 grant cycles
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.req = 8'hFF;
    tick();
    for (int i = 0; i < 9; i++) begin
      k = i % 8;
      chk("rot_gnt", bus.gnt, 8'h01 << k);
      chk("rot_idx", {5'd0, bus.gnt_idx}, 8'(k));
      tick();
      tick();
      bus.req[k] = 1'b0;
      tick();
      chk("rot_gap", {bus.gnt_valid, bus.gnt[6:0]}, 8'h00);
      bus.req[k] = (i == 8) ? 1'b0 : 1'b1;
      tick();
      chk("rot_idle", bus.gnt, 8'h00);
      if (i == 8) bus.req = 8'h00;
      tick();
    end
    chk("rot_end_idle", bus.gnt, 8'h00);

    // Hold expiry: ptr=1, only requester 4 held
    bus.req = 8'h10;
    tick();
    for (int c = 0; c < 16; c++) begin
      chk("hold_gnt", bus.gnt, 8'h10);
      chk("hold_no_to", {7'd0, bus.timeout}, 8'h00);
      tick();
    end
    chk_out("expiry_gap", 8'h00, 3'd4, 1'b0, 1'b1);
    tick();
    chk_out("expiry_idle", 8'h00, 3'd4, 1'b0, 1'b0);
    tick();
    chk_out("regrant4", 8'h10, 3'd4, 1'b1, 1'b0);

    // Release coinciding with expiry counts as release
    for (int c = 0; c < 15; c++) tick();
    chk("coinc_last", bus.gnt, 8'h10);
    bus.req = 8'h00;
    tick();
    chk_out("coinc_gap", 8'h00, 3'd4, 1'b0, 1'b0);
    tick();

    // Wrap-around: grant 6 so ptr becomes 7, then 0x81
    bus.req = 8'h40;
    tick();
    chk("wrap_g6", bus.gnt, 8'h40);
    bus.req = 8'h00;
    tick();
    tick();
    bus.req = 8'h81;
    tick();
    chk_out("wrap_g7", 8'h80, 3'd7, 1'b1, 1'b0);
    bus.req = 8'h01;
    tick();
    tick();
    tick();
    chk_out("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    tick();

    // Asynchronous reset during grant of 5, then restart from ptr=0
    bus.req = 8'h20;
    tick();
    chk_out("pre_rst_g5", 8'h20, 3'd5, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    bus.req = 8'h21;
    tick();
    chk_out("post_rst_g0", 8'h01, 3'd0, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    tick();

    // Enable gating: blocks new grants only
    bus.en  = 1'b0;
    bus.req = 8'h04;
    tick();
    chk("en_off_1", bus.gnt, 8'h00);
    tick();
    chk("en_off_2", bus.gnt, 8'h00);
    bus.en = 1'b1;
    tick();
    chk_out("en_on_g2", 8'h04, 3'd2, 1'b1, 1'b0);
    bus.en = 1'b0;
    tick();
    chk("en_drop_hold1", bus.gnt, 8'h04);
    tick();
    chk("en_drop_hold2", bus.gnt, 8'h04);
    bus.req = 8'h00;
    tick();
    chk_out("en_release_gap", 8'h00, 3'd2, 1'b0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: MAX_HOLD, 16, maximum consecutive GRANT cycles per grant (legal range 2..255).
REQ-002 Parameter: CNT_W, 8, hold-counter width; must satisfy 2**CNT_W > MAX_HOLD.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: en  input  1  arbitration enable; low blocks new grants only.
REQ-006 Port: req  input  8  request vector, bit n = requester n; held high while access is wanted.
REQ-007 Port: gnt  output  8  one-hot grant vector, all-zero when no grant.
REQ-008 Port: gnt_idx  output  3  binary index of current or last grantee.
REQ-009 Port: gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-010 Port: timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-011 FSM states SHALL be IDLE, GRANT and GAP; all outputs SHALL be registered.
REQ-012 IDLE: if en=1 and req!=0, the arbiter SHALL select the first set req bit searching upward from ptr, wrapping 7->0, then enter GRANT on the next edge with gnt_idx = selected index; otherwise it stays in IDLE.
REQ-013 Latency SHALL be one cycle from a req sampled high in IDLE to gnt/gnt_valid high.
REQ-014 In GRANT, gnt SHALL equal the 3-to-8 one-hot decode of gnt_idx, and gnt_valid SHALL be 1.
REQ-015 hold_cnt SHALL clear on entry to GRANT and increment by 1 each GRANT cycle.
REQ-016 GRANT SHALL exit to GAP when req[gnt_idx]=0 (release) or hold_cnt = MAX_HOLD-1 (expiry), whichever occurs first.
REQ-017 On expiry with req[gnt_idx] still 1, timeout SHALL pulse high for the single GAP cycle; on a normal release, timeout SHALL stay 0.
REQ-018 When release and expiry coincide in the same cycle, the exit SHALL be treated as a release (timeout=0).
REQ-019 On leaving GRANT, ptr SHALL be set to gnt_idx+1 mod 8 (7 wraps to 0).
REQ-020 GAP SHALL last exactly one cycle with gnt=0 and gnt_valid=0, then return to IDLE.
REQ-021 Minimum spacing between two grants SHALL therefore be two idle cycles (GAP + IDLE arbitration).
REQ-022 en falling during GRANT SHALL NOT revoke the current grant.
REQ-023 Requests on bits other than gnt_idx during GRANT SHALL be ignored until the next IDLE.
REQ-024 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-025 While rst=1, outputs SHALL be forced immediately, independent of clk: state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, ptr=0, hold_cnt=0.
REQ-026 Reset asserted mid-GRANT SHALL drop gnt in the same cycle; after deassertion, arbitration SHALL restart from ptr=0.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, GRANT=2'd1, GAP=2'd2) and the requester-count constant (8).
REQ-028 The one-hot decode SHALL be a single instance of the team's existing dec3to8 decoder driven by gnt_idx; its output SHALL be gated by gnt_valid.
REQ-029 The round-robin priority search SHALL be a combinational function within rr_arbiter8; no further sub-modules.

Verification
REQ-030 Reset, then req=8'h01 -> gnt=8'h01 and gnt_idx=0 one cycle later; drop req -> gnt=0 next cycle, then GAP, then IDLE.
REQ-031 req=8'hFF held with requesters releasing after 3 cycles each -> grant order 0,1,2,...,7,0, with two zero-grant cycles between grants.
REQ-032 req=8'h10 held, MAX_HOLD=16 -> gnt=8'h10 for exactly 16 cycles, then timeout=1 for one cycle, then re-grant of 4 after IDLE.
REQ-033 ptr=7 (previous grantee 6), req=8'h81 -> bit 7 granted first, then bit 0 (wrap-around).
REQ-034 rst pulsed mid-cycle during GRANT of idx 5 -> gnt=0 before the next clk edge; after release with req=8'h21, idx 0 is granted.
REQ-035 en=0 with req=8'h04 -> no grant; en=1 -> gnt=8'h04 next cycle; en=0 during GRANT -> grant retained until release.
